rx_pkt_ctrl: RTL and testbench

- Sequences the packet buffer behind the receive packet FSM.
- Writes each RXVALID word into a circular packet buffer and holds the packet's start address. At packet end it either commits the packet or rolls it back, using the CRC verdict, overflow status and descriptor space.
- Committed packets go to an internal descriptor FIFO for the readout engine.
- Keeps saturating good, bad and overflow packet counters.

---
 rtl/rx_pkt_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_rx_pkt_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_pkt_ctrl.sv
// -----------------------------------------------------------------------------
// rx_pkt_ctrl
//
// Purpose:
//   Buffer sequencer that sits behind the receive packet FSM. Each RXVALID word
//   is written into a circular packet buffer. The first-word address of the
//   packet in progress is held in a register. When the packet ends, the packet
//   is either committed or rolled back. The decision uses the CRC verdict, the
//   overflow status and the free space in the descriptor FIFO. Each committed
//   packet becomes a {start, length} descriptor in an internal FIFO, which the
//   readout engine drains. Saturating statistics counters track good, bad and
//   overflowed packets.
//
// Ports:
//   CLK, RST_N             clock, asynchronous active-low reset
//   RXVALID                payload word valid
//   CKCRC                  packet ended, CRC check requested
//   DROP                   packet aborted
//   CLR                    receive FSM back in wait-for-packet (leaves FLUSH)
//   CRC_VALID, CRC_OK      CRC verdict strobe and verdict
//   RD_PTR                 consumer's next read address (frees buffer space)
//   WR_EN, WR_ADDR         packet buffer write port
//   DESC_VALID, DESC_RD    descriptor FIFO head handshake
//   DESC_START, DESC_LEN   head descriptor contents (0 when empty)
//   GOOD_CNT, BAD_CNT,
//   OVF_CNT                saturating packet counters
//   CTRL_STATE             FSM state: IDLE=0, RECV=1, CRC_WAIT=2, FLUSH=3
//
// Descriptor handshake: DESC_VALID=1 means DESC_START/DESC_LEN hold the head
// entry. The entry is consumed on any rising CLK edge where DESC_VALID and
// DESC_RD are both 1. DESC_RD has no effect while DESC_VALID=0. A push and a
// pop may occur on the same edge. The "FIFO full" test used for the commit
// decision looks at the occupancy before that edge's pop.
// -----------------------------------------------------------------------------
module rx_pkt_ctrl #(
  parameter int ADDR_W      = 12,
  parameter int DESC_AW     = 3,
  parameter int CRC_TIMEOUT = 8,
  parameter int CNT_W       = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              RXVALID,
  input  logic              CKCRC,
  input  logic              DROP,
  input  logic              CLR,
  input  logic              CRC_VALID,
  input  logic              CRC_OK,
  input  logic [ADDR_W-1:0] RD_PTR,
  output logic              WR_EN,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic              DESC_VALID,
  output logic [ADDR_W-1:0] DESC_START,
  output logic [ADDR_W-1:0] DESC_LEN,
  input  logic              DESC_RD,
  output logic [CNT_W-1:0]  GOOD_CNT,
  output logic [CNT_W-1:0]  BAD_CNT,
  output logic [CNT_W-1:0]  OVF_CNT,
  output logic [1:0]        CTRL_STATE
);

  localparam int DESC_DEPTH = 1 << DESC_AW;
  localparam int TMO_W      = (CRC_TIMEOUT < 2) ? 1 : $clog2(CRC_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RECV     = 2'd1,
    ST_CRC_WAIT = 2'd2,
    ST_FLUSH    = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] wr_ptr_inc;
  logic [ADDR_W-1:0] commit_ptr;
  logic [ADDR_W-1:0] start;
  logic [ADDR_W-1:0] pkt_len;
  logic              ovf;
  logic [TMO_W-1:0]  tmo_cnt;

  logic in_rx;
  logic buf_full;
  logic ovf_set;
  logic tmo_expire;

  logic do_rollback;
  logic do_commit;
  logic tmo_load;
  logic inc_good;
  logic inc_bad;
  logic inc_ovf;

  // Descriptor FIFO storage and bookkeeping
  logic [ADDR_W-1:0]  desc_start_mem [DESC_DEPTH];
  logic [ADDR_W-1:0]  desc_len_mem   [DESC_DEPTH];
  logic [DESC_AW-1:0] desc_wr_idx;
  logic [DESC_AW-1:0] desc_rd_idx;
  logic [DESC_AW:0]   desc_count;
  logic               desc_full;
  logic               desc_push;
  logic               desc_pop;

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  assign wr_ptr_inc = wr_ptr + ADDR_W'(1);
  assign pkt_len    = wr_ptr - start;

  // One slot always stays empty, so wr_ptr == RD_PTR can only mean "empty".
  assign buf_full = (wr_ptr_inc == RD_PTR);
  assign in_rx    = (state == ST_IDLE) || (state == ST_RECV);

  // The reset term keeps WR_EN low during reset even if RXVALID stays high.
  assign WR_EN   = RXVALID & ~buf_full & ~ovf & in_rx & RST_N;
  assign ovf_set = RXVALID & buf_full & in_rx;
  assign WR_ADDR = wr_ptr;

  // The counter is loaded on entry to CRC_WAIT and counts down once per cycle
  // spent there. The verdict window expires on the cycle it would reach 0, so
  // the packet spends exactly CRC_TIMEOUT cycles in CRC_WAIT.
  assign tmo_expire = (tmo_cnt <= TMO_W'(1));

  // ---------------------------------------------------------------------------
  // Control FSM: next state and packet-end actions
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    do_rollback = 1'b0;
    do_commit   = 1'b0;
    tmo_load    = 1'b0;
    inc_good    = 1'b0;
    inc_bad     = 1'b0;
    inc_ovf     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (DROP) begin
          do_rollback = 1'b1;
          inc_bad     = 1'b1;
          state_nxt   = ST_FLUSH;
        end else if (CKCRC) begin
          tmo_load    = 1'b1;
          state_nxt   = ST_CRC_WAIT;
        end else if (RXVALID) begin
          state_nxt   = ST_RECV;
        end
      end

      ST_RECV: begin
        // DROP takes priority over a simultaneous CKCRC.
        if (DROP) begin
          do_rollback = 1'b1;
          inc_bad     = 1'b1;
          state_nxt   = ST_FLUSH;
        end else if (CKCRC) begin
          tmo_load    = 1'b1;
          state_nxt   = ST_CRC_WAIT;
        end
      end

      ST_CRC_WAIT: begin
        if (CRC_VALID || tmo_expire) begin
          state_nxt = ST_FLUSH;
          if (ovf || desc_full) begin
            do_rollback = 1'b1;
            inc_ovf     = 1'b1;
          end else if (!CRC_VALID || !CRC_OK) begin
            // A verdict that arrives on the expiry cycle is still honoured.
            do_rollback = 1'b1;
            inc_bad     = 1'b1;
          end else if (wr_ptr == start) begin
            do_rollback = 1'b1;
            inc_bad     = 1'b1;
          end else begin
            do_commit   = 1'b1;
            inc_good    = 1'b1;
          end
        end
      end

      ST_FLUSH: begin
        if (CLR) begin
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign CTRL_STATE = state;

  // ---------------------------------------------------------------------------
  // Pointers, overflow flag and CRC timeout
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      start      <= '0;
      ovf        <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      // A rollback discards every word written since the last commit. This
      // includes a word written in the same cycle as a DROP from IDLE.
      if (do_rollback) begin
        wr_ptr <= commit_ptr;
      end else if (WR_EN) begin
        wr_ptr <= wr_ptr_inc;
      end

      if (do_commit) begin
        commit_ptr <= wr_ptr;
      end

      if (do_rollback || do_commit) begin
        ovf <= 1'b0;
      end else if (ovf_set) begin
        ovf <= 1'b1;
      end

      // While idle, start tracks the commit point, so the first word of the
      // next packet lands at start.
      if (state == ST_IDLE) begin
        start <= commit_ptr;
      end

      if (tmo_load) begin
        tmo_cnt <= TMO_W'(CRC_TIMEOUT);
      end else if (state == ST_CRC_WAIT && tmo_cnt != '0) begin
        tmo_cnt <= tmo_cnt - TMO_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Descriptor FIFO
  // ---------------------------------------------------------------------------
  assign desc_full  = (desc_count == (DESC_AW + 1)'(DESC_DEPTH));
  assign desc_push  = do_commit;
  assign desc_pop   = DESC_RD && (desc_count != '0);
  assign DESC_VALID = (desc_count != '0);

  // Both head fields read as 0 while the FIFO is empty, so they never show
  // stale or uninitialised entries.
  assign DESC_START = DESC_VALID ? desc_start_mem[desc_rd_idx] : '0;
  assign DESC_LEN   = DESC_VALID ? desc_len_mem[desc_rd_idx]   : '0;

  always_ff @(posedge CLK) begin
    if (desc_push) begin
      desc_start_mem[desc_wr_idx] <= start;
      desc_len_mem[desc_wr_idx]   <= pkt_len;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      desc_wr_idx <= '0;
      desc_rd_idx <= '0;
      desc_count  <= '0;
    end else begin
      if (desc_push) begin
        desc_wr_idx <= desc_wr_idx + DESC_AW'(1);
      end
      if (desc_pop) begin
        desc_rd_idx <= desc_rd_idx + DESC_AW'(1);
      end
      case ({desc_push, desc_pop})
        2'b10:   desc_count <= desc_count + (DESC_AW + 1)'(1);
        2'b01:   desc_count <= desc_count - (DESC_AW + 1)'(1);
        default: desc_count <= desc_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating statistics counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      GOOD_CNT <= '0;
      BAD_CNT  <= '0;
      OVF_CNT  <= '0;
    end else begin
      if (inc_good && GOOD_CNT != '1) begin
        GOOD_CNT <= GOOD_CNT + CNT_W'(1);
      end
      if (inc_bad && BAD_CNT != '1) begin
        BAD_CNT <= BAD_CNT + CNT_W'(1);
      end
      if (inc_ovf && OVF_CNT != '1) begin
        OVF_CNT <= OVF_CNT + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rx_pkt_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rx_pkt_ctrl
//
// Directed bench for rx_pkt_ctrl. The main instance uses the default
// parameters. A second instance uses ADDR_W=4 and CNT_W=2, which exercises
// buffer-full overflow and counter saturation in a few cycles. Inputs change
// 1 time unit after the rising edge. Outputs are sampled at least 1 time unit
// after the rising edge, or 1 time unit after the inputs change for
// combinational outputs.
// -----------------------------------------------------------------------------
module tb_rx_pkt_ctrl;

  localparam int AW  = 12;
  localparam int CW  = 16;
  localparam int SAW = 4;
  localparam int SCW = 2;

  // ---------------------------------------------------------------------------
  // Clock and reset
  // ---------------------------------------------------------------------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Main instance signals
  // ---------------------------------------------------------------------------
  logic          rxvalid, ckcrc, drop, clr, crc_valid, crc_ok, desc_rd;
  logic [AW-1:0] rd_ptr;
  logic          wr_en, desc_valid;
  logic [AW-1:0] wr_addr, desc_start, desc_len;
  logic [CW-1:0] good_cnt, bad_cnt, ovf_cnt;
  logic [1:0]    ctrl_state;

  rx_pkt_ctrl u_dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .RXVALID    (rxvalid),
    .CKCRC      (ckcrc),
    .DROP       (drop),
    .CLR        (clr),
    .CRC_VALID  (crc_valid),
    .CRC_OK     (crc_ok),
    .RD_PTR     (rd_ptr),
    .WR_EN      (wr_en),
    .WR_ADDR    (wr_addr),
    .DESC_VALID (desc_valid),
    .DESC_START (desc_start),
    .DESC_LEN   (desc_len),
    .DESC_RD    (desc_rd),
    .GOOD_CNT   (good_cnt),
    .BAD_CNT    (bad_cnt),
    .OVF_CNT    (ovf_cnt),
    .CTRL_STATE (ctrl_state)
  );

  // ---------------------------------------------------------------------------
  // Small instance signals
  // ---------------------------------------------------------------------------
  logic           s_rxvalid, s_ckcrc, s_clr, s_crc_valid, s_crc_ok;
  logic           s_wr_en, s_desc_valid;
  logic [SAW-1:0] s_wr_addr, s_desc_start, s_desc_len;
  logic [SCW-1:0] s_good_cnt, s_bad_cnt, s_ovf_cnt;
  logic [1:0]     s_state;

  rx_pkt_ctrl #(.ADDR_W(SAW), .CNT_W(SCW)) u_dut_small (
    .CLK        (clk),
    .RST_N      (rst_n),
    .RXVALID    (s_rxvalid),
    .CKCRC      (s_ckcrc),
    .DROP       (1'b0),
    .CLR        (s_clr),
    .CRC_VALID  (s_crc_valid),
    .CRC_OK     (s_crc_ok),
    .RD_PTR     (4'd0),
    .WR_EN      (s_wr_en),
    .WR_ADDR    (s_wr_addr),
    .DESC_VALID (s_desc_valid),
    .DESC_START (s_desc_start),
    .DESC_LEN   (s_desc_len),
    .DESC_RD    (1'b0),
    .GOOD_CNT   (s_good_cnt),
    .BAD_CNT    (s_bad_cnt),
    .OVF_CNT    (s_ovf_cnt),
    .CTRL_STATE (s_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard: expected descriptors {start, len}
  // ---------------------------------------------------------------------------
  logic [2*AW-1:0] exp_q[$];
  logic [2*AW-1:0] exp_d;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Compare the FIFO head with the next expected descriptor.
  task automatic chk_head(input string tag);
    exp_d = exp_q.pop_front();
    chk({tag, "_valid"}, 32'(desc_valid), 32'd1);
    chk({tag, "_start"}, 32'(desc_start), 32'(exp_d[2*AW-1:AW]));
    chk({tag, "_len"},   32'(desc_len),   32'(exp_d[AW-1:0]));
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // n words, CKCRC, good verdict on the next cycle (optionally with a
  // descriptor pop on that same cycle), then CLR.
  task automatic run_pkt(input int n, input logic pop_on_verdict);
    for (int i = 0; i < n; i++) begin
      rxvalid = 1'b1;
      step();
    end
    rxvalid   = 1'b0;
    ckcrc     = 1'b1;
    step();
    ckcrc     = 1'b0;
    crc_valid = 1'b1;
    crc_ok    = 1'b1;
    desc_rd   = pop_on_verdict;
    step();
    crc_valid = 1'b0;
    crc_ok    = 1'b0;
    desc_rd   = 1'b0;
    clr       = 1'b1;
    step();
    clr       = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int n_wr;

    rxvalid = 0; ckcrc = 0; drop = 0; clr = 0; crc_valid = 0; crc_ok = 0;
    desc_rd = 0; rd_ptr = '0;
    s_rxvalid = 0; s_ckcrc = 0; s_clr = 0; s_crc_valid = 0; s_crc_ok = 0;

    // ---- Reset state ----
    #2;
    chk("rst_state",      32'(ctrl_state), 32'd0);
    chk("rst_wr_en",      32'(wr_en),      32'd0);
    chk("rst_wr_addr",    32'(wr_addr),    32'd0);
    chk("rst_desc_valid", 32'(desc_valid), 32'd0);
    chk("rst_good",       32'(good_cnt),   32'd0);
    chk("rst_bad",        32'(bad_cnt),    32'd0);
    chk("rst_ovf",        32'(ovf_cnt),    32'd0);
    step();
    rst_n = 1'b1;
    step();

    // ---- 1: 10-word good packet ----
    for (int i = 0; i < 10; i++) begin
      rxvalid = 1'b1;
      #1;
      chk("t1_wr_en",   32'(wr_en),   32'd1);
      chk("t1_wr_addr", 32'(wr_addr), 32'(i));
      step();
    end
    chk("t1_recv", 32'(ctrl_state), 32'd1);
    rxvalid = 1'b0;
    ckcrc   = 1'b1;
    #1;
    chk("t1_no_wr", 32'(wr_en), 32'd0);
    step();
    ckcrc = 1'b0;
    chk("t1_crc_wait", 32'(ctrl_state), 32'd2);
    step();
    step();
    crc_valid = 1'b1;
    crc_ok    = 1'b1;
    step();
    crc_valid = 1'b0;
    crc_ok    = 1'b0;
    exp_q.push_back({12'd0, 12'd10});
    chk("t1_flush",   32'(ctrl_state), 32'd3);
    chk("t1_good",    32'(good_cnt),   32'd1);
    chk("t1_wr_addr_commit", 32'(wr_addr), 32'd10);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t1_idle", 32'(ctrl_state), 32'd0);
    chk_head("t1_desc");
    desc_rd = 1'b1;
    step();
    desc_rd = 1'b0;
    chk("t1_popped", 32'(desc_valid), 32'd0);

    // ---- 2: DROP with simultaneous CKCRC ----
    for (int i = 0; i < 5; i++) begin
      rxvalid = 1'b1;
      #1;
      chk("t2_wr_addr", 32'(wr_addr), 32'(10 + i));
      step();
    end
    rxvalid = 1'b0;
    drop    = 1'b1;
    ckcrc   = 1'b1;
    step();
    drop  = 1'b0;
    ckcrc = 1'b0;
    chk("t2_flush",      32'(ctrl_state), 32'd3);
    chk("t2_bad",        32'(bad_cnt),    32'd1);
    chk("t2_rollback",   32'(wr_addr),    32'd10);
    chk("t2_no_desc",    32'(desc_valid), 32'd0);
    chk("t2_good_hold",  32'(good_cnt),   32'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;

    // ---- 4: CRC timeout, late CRC_VALID in FLUSH ----
    rxvalid = 1'b1;
    #1;
    chk("t4_next_start", 32'(wr_addr), 32'd10);
    step();
    step();
    rxvalid = 1'b0;
    ckcrc   = 1'b1;
    step();
    ckcrc = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      chk("t4_still_wait", 32'(ctrl_state), 32'd2);
      step();
    end
    chk("t4_timeout_flush", 32'(ctrl_state), 32'd3);
    chk("t4_bad",           32'(bad_cnt),    32'd2);
    chk("t4_rollback",      32'(wr_addr),    32'd10);
    crc_valid = 1'b1;
    crc_ok    = 1'b1;
    step();
    crc_valid = 1'b0;
    crc_ok    = 1'b0;
    chk("t4_late_state", 32'(ctrl_state), 32'd3);
    chk("t4_late_good",  32'(good_cnt),   32'd1);
    chk("t4_late_desc",  32'(desc_valid), 32'd0);
    chk("t4_late_bad",   32'(bad_cnt),    32'd2);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t4_idle", 32'(ctrl_state), 32'd0);

    // ---- 6a: zero-length packet with good CRC ----
    ckcrc = 1'b1;
    step();
    ckcrc = 1'b0;
    chk("t6_crc_wait", 32'(ctrl_state), 32'd2);
    crc_valid = 1'b1;
    crc_ok    = 1'b1;
    step();
    crc_valid = 1'b0;
    crc_ok    = 1'b0;
    chk("t6_zero_bad",   32'(bad_cnt),    32'd3);
    chk("t6_zero_good",  32'(good_cnt),   32'd1);
    chk("t6_zero_desc",  32'(desc_valid), 32'd0);
    chk("t6_zero_flush", 32'(ctrl_state), 32'd3);
    clr = 1'b1;
    step();
    clr = 1'b0;

    // ---- 6b: reset pulsed mid-RECV ----
    rxvalid = 1'b1;
    step();
    step();
    chk("t6_recv",     32'(ctrl_state), 32'd1);
    chk("t6_wr_addr",  32'(wr_addr),    32'd12);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_state", 32'(ctrl_state), 32'd0);
    chk("t6_rst_wr_en", 32'(wr_en),      32'd0);
    chk("t6_rst_addr",  32'(wr_addr),    32'd0);
    chk("t6_rst_good",  32'(good_cnt),   32'd0);
    chk("t6_rst_bad",   32'(bad_cnt),    32'd0);
    chk("t6_rst_desc",  32'(desc_valid), 32'd0);
    rxvalid = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // ---- 5: descriptor FIFO full ----
    for (int p = 0; p < 8; p++) begin
      run_pkt(3, 1'b0);
      exp_q.push_back({12'(3 * p), 12'd3});
    end
    chk("t5_good8",      32'(good_cnt),   32'd8);
    chk("t5_head_start", 32'(desc_start), 32'd0);
    run_pkt(3, 1'b0);
    chk("t5_ovf1",       32'(ovf_cnt),    32'd1);
    chk("t5_good_hold",  32'(good_cnt),   32'd8);
    chk("t5_rollback",   32'(wr_addr),    32'd24);
    // Pop on the verdict cycle: the FIFO is still counted as full.
    chk_head("t5_pop0");
    run_pkt(3, 1'b1);
    chk("t5_ovf2",       32'(ovf_cnt),    32'd2);
    chk("t5_good_hold2", 32'(good_cnt),   32'd8);
    // Commit and pop on the same edge, with 7 entries present.
    chk_head("t5_pop3");
    run_pkt(3, 1'b1);
    exp_q.push_back({12'd24, 12'd3});
    chk("t5_good9",      32'(good_cnt),   32'd9);
    chk("t5_ovf_hold",   32'(ovf_cnt),    32'd2);
    while (exp_q.size() > 0) begin
      chk_head("t5_drain");
      desc_rd = 1'b1;
      step();
      desc_rd = 1'b0;
    end
    chk("t5_empty", 32'(desc_valid), 32'd0);

    // ---- 3: buffer overflow on a 16-word buffer, counter saturation ----
    for (int p = 0; p < 4; p++) begin
      n_wr = 0;
      for (int i = 0; i < 20; i++) begin
        s_rxvalid = 1'b1;
        #1;
        if (s_wr_en) n_wr++;
        step();
      end
      s_rxvalid = 1'b0;
      chk("t3_writes",   32'(n_wr),      32'd15);
      chk("t3_wr_stuck", 32'(s_wr_addr), 32'd15);
      s_ckcrc = 1'b1;
      step();
      s_ckcrc     = 1'b0;
      s_crc_valid = 1'b1;
      s_crc_ok    = 1'b1;
      step();
      s_crc_valid = 1'b0;
      s_crc_ok    = 1'b0;
      chk("t3_ovf_cnt",  32'(s_ovf_cnt),    32'((p < 3) ? p + 1 : 3));
      chk("t3_rollback", 32'(s_wr_addr),    32'd0);
      chk("t3_no_desc",  32'(s_desc_valid), 32'd0);
      chk("t3_good",     32'(s_good_cnt),   32'd0);
      chk("t3_flush",    32'(s_state),      32'd3);
      s_clr = 1'b1;
      step();
      s_clr = 1'b0;
    end
    chk("t3_bad", 32'(s_bad_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
